// File: rtl/pixel_word_packer.sv
// pixel_word_packer
//
// Packs 8-bit framebuffer pixels into 32-bit words with byte strobes. Pixels
// whose byte addresses fall in the same 4-byte word are merged, so the
// downstream AXI master issues fewer write beats. One word is accumulated at a
// time. It is emitted when all four lanes are written, when a pixel for a
// different word arrives, after an idle timeout, or when the frame ends.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   framebuffer_baseaddr    byte base address of the framebuffer
//   width                   framebuffer width in pixels (stable during a frame)
//   pixel_x/_y/_data        pixel coordinate and colour
//   pixel_valid/ready       pixel handshake; draw=0 pixels are accepted and dropped
//   draw                    1 = write the pixel, 0 = discard it
//   frame_end               one-cycle pulse after the last pixel of a frame
//   word_addr/data/strb     packed output word (addr is 4-byte aligned)
//   word_valid/ready        output word handshake
//   flush_done              one-cycle pulse once the frame is fully drained
module pixel_word_packer #(
    parameter int unsigned IDLE_FLUSH = 16,
    parameter int unsigned XY_W       = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     framebuffer_baseaddr,
    input  logic [XY_W-1:0] width,
    input  logic [XY_W-1:0] pixel_x,
    input  logic [XY_W-1:0] pixel_y,
    input  logic [7:0]      pixel_data,
    input  logic            pixel_valid,
    input  logic            draw,
    output logic            pixel_ready,
    input  logic            frame_end,
    output logic [31:0]     word_addr,
    output logic [31:0]     word_data,
    output logic [3:0]      word_strb,
    output logic            word_valid,
    input  logic            word_ready,
    output logic            flush_done
);

    localparam int unsigned IdxW = 2 * XY_W;
    localparam int unsigned CntW = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(IDLE_FLUSH);

    // Accumulator
    logic            acc_valid_q, acc_valid_d;
    logic [31:0]     acc_addr_q, acc_addr_d;
    logic [31:0]     acc_data_q, acc_data_d;
    logic [3:0]      acc_strb_q, acc_strb_d;

    // Output register
    logic            word_valid_q, word_valid_d;
    logic [31:0]     word_addr_q, word_addr_d;
    logic [31:0]     word_data_q, word_data_d;
    logic [3:0]      word_strb_q, word_strb_d;

    logic            flush_pending_q, flush_pending_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

    // Address decode
    logic [IdxW-1:0] pix_index;
    logic [31:0]     byte_addr;
    logic [31:0]     pix_group;
    logic [1:0]      pix_lane;
    logic [3:0]      pix_strb;
    logic [31:0]     pix_word;

    assign pix_index = {{XY_W{1'b0}}, pixel_y} * {{XY_W{1'b0}}, width}
                     + {{XY_W{1'b0}}, pixel_x};
    assign byte_addr = framebuffer_baseaddr + 32'(pix_index);
    assign pix_group = {byte_addr[31:2], 2'b00};
    assign pix_lane  = byte_addr[1:0];
    assign pix_strb  = 4'b0001 << pix_lane;
    assign pix_word  = {24'h0, pixel_data} << {pix_lane, 3'b000};

    // Handshake and control terms
    logic out_free;
    logic accept;
    logic draw_accept;
    logic same_group;
    logic idle_hit;
    logic flush_acc;

    // The output slot can take a word this edge if it is empty or being drained.
    assign out_free    = !word_valid_q || word_ready;
    assign pixel_ready = !reset && !flush_pending_q && out_free;
    assign accept      = pixel_valid && pixel_ready;
    assign draw_accept = accept && draw;
    assign same_group  = acc_valid_q && (acc_addr_q == pix_group);
    assign idle_hit    = (IDLE_FLUSH != 0) && (idle_cnt_q == CntMax);
    // A drawn pixel takes priority; flush_pending blocks accepts anyway.
    assign flush_acc   = acc_valid_q && out_free && !draw_accept
                       && (flush_pending_q || idle_hit);
    assign flush_done  = !reset && flush_pending_q && !acc_valid_q && !word_valid_q;

    assign word_valid = word_valid_q;
    assign word_addr  = word_addr_q;
    assign word_data  = word_data_q;
    assign word_strb  = word_strb_q;

    // Lane merge of the incoming pixel into the held word (last write wins).
    logic [31:0] merged_data;
    logic [3:0]  merged_strb;

    always_comb begin
        merged_strb = acc_strb_q | pix_strb;
        merged_data = acc_data_q;
        for (int n = 0; n < 4; n++) begin
            if (pix_strb[n]) begin
                merged_data[8*n +: 8] = pixel_data;
            end
        end
    end

    always_comb begin
        acc_valid_d     = acc_valid_q;
        acc_addr_d      = acc_addr_q;
        acc_data_d      = acc_data_q;
        acc_strb_d      = acc_strb_q;
        word_valid_d    = word_valid_q && !word_ready;
        word_addr_d     = word_addr_q;
        word_data_d     = word_data_q;
        word_strb_d     = word_strb_q;
        idle_cnt_d      = idle_cnt_q;
        flush_pending_d = flush_pending_q;

        if (draw_accept) begin
            idle_cnt_d = '0;
            if (same_group) begin
                if (merged_strb == 4'hF) begin
                    // Word complete: bypass straight to the output register.
                    word_valid_d = 1'b1;
                    word_addr_d  = acc_addr_q;
                    word_data_d  = merged_data;
                    word_strb_d  = 4'hF;
                    acc_valid_d  = 1'b0;
                    acc_strb_d   = '0;
                end else begin
                    acc_data_d = merged_data;
                    acc_strb_d = merged_strb;
                end
            end else begin
                // New group: retire the held word (if any) and start a new one.
                if (acc_valid_q) begin
                    word_valid_d = 1'b1;
                    word_addr_d  = acc_addr_q;
                    word_data_d  = acc_data_q;
                    word_strb_d  = acc_strb_q;
                end
                acc_valid_d = 1'b1;
                acc_addr_d  = pix_group;
                acc_data_d  = pix_word;
                acc_strb_d  = pix_strb;
            end
        end else if (flush_acc) begin
            word_valid_d = 1'b1;
            word_addr_d  = acc_addr_q;
            word_data_d  = acc_data_q;
            word_strb_d  = acc_strb_q;
            acc_valid_d  = 1'b0;
            acc_strb_d   = '0;
            idle_cnt_d   = '0;
        end else if (acc_valid_q && (idle_cnt_q != CntMax)) begin
            idle_cnt_d = idle_cnt_q + CntW'(1);
        end

        if (flush_done) begin
            flush_pending_d = 1'b0;
        end
        if (frame_end) begin
            flush_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_valid_q     <= 1'b0;
            acc_addr_q      <= '0;
            acc_data_q      <= '0;
            acc_strb_q      <= '0;
            word_valid_q    <= 1'b0;
            word_addr_q     <= '0;
            word_data_q     <= '0;
            word_strb_q     <= '0;
            flush_pending_q <= 1'b0;
            idle_cnt_q      <= '0;
        end else begin
            acc_valid_q     <= acc_valid_d;
            acc_addr_q      <= acc_addr_d;
            acc_data_q      <= acc_data_d;
            acc_strb_q      <= acc_strb_d;
            word_valid_q    <= word_valid_d;
            word_addr_q     <= word_addr_d;
            word_data_q     <= word_data_d;
            word_strb_q     <= word_strb_d;
            flush_pending_q <= flush_pending_d;
            idle_cnt_q      <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_pixel_word_packer.sv
// tb_pixel_word_packer
//
// Self-checking bench for pixel_word_packer. Expected output words are queued
// when pixels are driven and popped by a monitor on each output handshake.
module tb_pixel_word_packer;

    localparam int unsigned IdleFlush = 16;
    localparam int unsigned XyW       = 11;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    framebuffer_baseaddr;
    logic [XyW-1:0] width;
    logic [XyW-1:0] pixel_x;
    logic [XyW-1:0] pixel_y;
    logic [7:0]     pixel_data;
    logic           pixel_valid;
    logic           draw;
    logic           pixel_ready;
    logic           frame_end;
    logic [31:0]    word_addr;
    logic [31:0]    word_data;
    logic [3:0]     word_strb;
    logic           word_valid;
    logic           word_ready;
    logic           flush_done;

    always #5 clk = ~clk;

    pixel_word_packer #(
        .IDLE_FLUSH(IdleFlush),
        .XY_W      (XyW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .framebuffer_baseaddr(framebuffer_baseaddr),
        .width               (width),
        .pixel_x             (pixel_x),
        .pixel_y             (pixel_y),
        .pixel_data          (pixel_data),
        .pixel_valid         (pixel_valid),
        .draw                (draw),
        .pixel_ready         (pixel_ready),
        .frame_end           (frame_end),
        .word_addr           (word_addr),
        .word_data           (word_data),
        .word_strb           (word_strb),
        .word_valid          (word_valid),
        .word_ready          (word_ready),
        .flush_done          (flush_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } word_t;

    typedef struct {
        logic [31:0]    base;
        logic [XyW-1:0] w;
        logic [XyW-1:0] x;
        logic [XyW-1:0] y;
        logic [7:0]     col;
        logic [31:0]    exp_addr;
        logic [31:0]    exp_data;
        logic [3:0]     exp_strb;
    } vec_t;

    word_t exp_q[$];
    word_t mon_e;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        word_t e;
        e.addr = a;
        e.data = d;
        e.strb = s;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every output handshake must match the next expected word.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got addr=0x%08h data=0x%08h strb=%b want none",
                         word_addr, word_data, word_strb);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word_addr", word_addr, mon_e.addr);
                chk("word_data", word_data, mon_e.data);
                chk("word_strb", {28'h0, word_strb}, {28'h0, mon_e.strb});
            end
        end
    end

    // Present one pixel and hold it until accepted; called just after a posedge.
    task automatic send(input logic [XyW-1:0] x, input logic [XyW-1:0] y,
                        input logic [7:0] d, input logic dr, input logic fe,
                        output int stalls);
        logic rdy;
        rdy         = 1'b0;
        stalls      = 0;
        pixel_x     = x;
        pixel_y     = y;
        pixel_data  = d;
        draw        = dr;
        frame_end   = fe;
        pixel_valid = 1'b1;
        for (int i = 0; i < 200 && !rdy; i++) begin
            @(negedge clk);
            rdy = pixel_ready;
            @(posedge clk);
            #1;
            frame_end = 1'b0;
            if (!rdy) stalls++;
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept within 200 cycles");
        end
    endtask

    task automatic idle();
        pixel_valid = 1'b0;
        draw        = 1'b0;
    endtask

    task automatic pulse_fe();
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = flush_done;
        end
        chk(name, {31'h0, seen}, 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   st;
        int   hs;
        int   dn;
        int   n;
        logic found;
        int   vcnt;

        vecs[0] = '{32'h1000_0000, 11'd800,  11'd3,    11'd2,    8'h5A,
                    32'h1000_0640, 32'h5A00_0000, 4'h8};
        vecs[1] = '{32'h8000_0001, 11'd640,  11'd0,    11'd0,    8'hC3,
                    32'h8000_0000, 32'h0000_C300, 4'h2};
        vecs[2] = '{32'h0000_0100, 11'd1920, 11'd1919, 11'd1079, 8'h7E,
                    32'h001F_A4FC, 32'h7E00_0000, 4'h8};
        vecs[3] = '{32'h0000_0000, 11'd2047, 11'd2047, 11'd2047, 8'h99,
                    32'h003F_F800, 32'h0000_0099, 4'h1};
        vecs[4] = '{32'hFFFF_FFFE, 11'd4,    11'd1,    11'd0,    8'h12,
                    32'hFFFF_FFFC, 32'h1200_0000, 4'h8};
        vecs[5] = '{32'h0000_0020, 11'd10,   11'd6,    11'd3,    8'hAB,
                    32'h0000_0044, 32'h0000_00AB, 4'h1};

        reset                = 1'b1;
        framebuffer_baseaddr = 32'h0;
        width                = 11'd800;
        pixel_x              = '0;
        pixel_y              = '0;
        pixel_data           = '0;
        pixel_valid          = 1'b0;
        draw                 = 1'b0;
        frame_end            = 1'b0;
        word_ready           = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_word_valid", {31'h0, word_valid}, 32'd0);
        chk("rst_word_addr", word_addr, 32'd0);
        chk("rst_word_data", word_data, 32'd0);
        chk("rst_word_strb", {28'h0, word_strb}, 32'd0);
        chk("rst_flush_done", {31'h0, flush_done}, 32'd0);
        chk("rst_pixel_ready", {31'h0, pixel_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_pixel_ready", {31'h0, pixel_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Address decode table: one pixel per frame, flushed by frame_end.
        for (int i = 0; i < 6; i++) begin
            framebuffer_baseaddr = vecs[i].base;
            width                = vecs[i].w;
            push_exp(vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_strb);
            send(vecs[i].x, vecs[i].y, vecs[i].col, 1'b1, 1'b1, st);
            idle();
            wait_done("vec_flush_done");
        end

        framebuffer_baseaddr = 32'h0;
        width                = 11'd800;

        // Four pixels complete a word; valid the cycle after the 4th accept.
        push_exp(32'h0, 32'h4433_2211, 4'hF);
        send(11'd0, 11'd0, 8'h11, 1'b1, 1'b0, st);
        send(11'd1, 11'd0, 8'h22, 1'b1, 1'b0, st);
        send(11'd2, 11'd0, 8'h33, 1'b1, 1'b0, st);
        send(11'd3, 11'd0, 8'h44, 1'b1, 1'b0, st);
        idle();
        @(negedge clk);
        chk("A_valid_next", {31'h0, word_valid}, 32'd1);
        chk("A_addr", word_addr, 32'h0);
        chk("A_data", word_data, 32'h4433_2211);
        chk("A_strb", {28'h0, word_strb}, 32'hF);
        @(posedge clk);
        #1;

        // Group change retires the partial word.
        push_exp(32'h4, 32'h0000_AA00, 4'b0010);
        push_exp(32'h64, 32'h0000_00BB, 4'b0001);
        send(11'd5, 11'd0, 8'hAA, 1'b1, 1'b0, st);
        send(11'd100, 11'd0, 8'hBB, 1'b1, 1'b0, st);
        idle();
        @(negedge clk);
        chk("B_valid", {31'h0, word_valid}, 32'd1);
        chk("B_addr", word_addr, 32'h4);
        @(posedge clk);
        #1;
        pulse_fe();
        wait_done("B_flush_done");

        // draw=0 pixel is accepted and dropped.
        push_exp(32'h0, 32'h0003_0001, 4'b0101);
        send(11'd0, 11'd0, 8'h01, 1'b1, 1'b0, st);
        send(11'd1, 11'd0, 8'hFF, 1'b0, 1'b0, st);
        chk("C_nodraw_stalls", 32'(st), 32'd0);
        send(11'd2, 11'd0, 8'h03, 1'b1, 1'b0, st);
        chk("C_draw_stalls", 32'(st), 32'd0);
        idle();
        pulse_fe();
        wait_done("C_flush_done");

        // Output back-pressure with a new-group pixel waiting.
        word_ready = 1'b0;
        push_exp(32'h0, 32'hA4A3_A2A1, 4'hF);
        push_exp(32'h8, 32'h0000_00B0, 4'b0001);
        send(11'd0, 11'd0, 8'hA1, 1'b1, 1'b0, st);
        send(11'd1, 11'd0, 8'hA2, 1'b1, 1'b0, st);
        send(11'd2, 11'd0, 8'hA3, 1'b1, 1'b0, st);
        send(11'd3, 11'd0, 8'hA4, 1'b1, 1'b0, st);
        pixel_x     = 11'd8;
        pixel_y     = 11'd0;
        pixel_data  = 8'hB0;
        draw        = 1'b1;
        pixel_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("D_ready_low", {31'h0, pixel_ready}, 32'd0);
            chk("D_valid_held", {31'h0, word_valid}, 32'd1);
            chk("D_addr_stable", word_addr, 32'h0);
            chk("D_data_stable", word_data, 32'hA4A3_A2A1);
            chk("D_strb_stable", {28'h0, word_strb}, 32'hF);
        end
        @(posedge clk);
        #1;
        word_ready = 1'b1;
        send(11'd8, 11'd0, 8'hB0, 1'b1, 1'b0, st);
        chk("D_release_stalls", 32'(st), 32'd0);
        idle();
        pulse_fe();
        wait_done("D_flush_done");

        // frame_end coincident with the last pixel; flush_done follows the handshake.
        push_exp(32'h320, 32'h005C_0000, 4'b0100);
        send(11'd2, 11'd1, 8'h5C, 1'b1, 1'b1, st);
        idle();
        hs = -1;
        dn = -1;
        for (int i = 0; i < 50 && dn < 0; i++) begin
            @(negedge clk);
            if (word_valid && word_ready && hs < 0) hs = i;
            if (flush_done) dn = i;
        end
        chk("E_done_after_hs", 32'(dn), 32'(hs + 1));
        @(negedge clk);
        chk("E_done_one_cycle", {31'h0, flush_done}, 32'd0);
        chk("E_queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Idle timeout releases a lone partial word.
        push_exp(32'h4, 32'hEE00_0000, 4'b1000);
        send(11'd7, 11'd0, 8'hEE, 1'b1, 1'b0, st);
        idle();
        n     = 0;
        found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (word_valid) begin
                found = 1'b1;
                n     = i;
            end
        end
        chk("F_idle_seen", {31'h0, found}, 32'd1);
        chk("F_not_early", {31'h0, n >= int'(IdleFlush)}, 32'd1);
        chk("F_not_late", {31'h0, n <= int'(IdleFlush) + 3}, 32'd1);
        @(posedge clk);
        #1;
        chk("F_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-word discards the held pixel.
        send(11'd1, 11'd0, 8'h77, 1'b1, 1'b0, st);
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("G_ready_in_reset", {31'h0, pixel_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("G_word_valid", {31'h0, word_valid}, 32'd0);
        chk("G_word_addr", word_addr, 32'd0);
        chk("G_word_data", word_data, 32'd0);
        chk("G_word_strb", {28'h0, word_strb}, 32'd0);
        chk("G_flush_done", {31'h0, flush_done}, 32'd0);
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (word_valid) vcnt++;
        end
        chk("G_no_word", 32'(vcnt), 32'd0);
        @(posedge clk);
        #1;

        // Empty frame: flush_done the cycle after frame_end.
        pulse_fe();
        @(negedge clk);
        chk("H_empty_done", {31'h0, flush_done}, 32'd1);
        @(negedge clk);
        chk("H_empty_done_pulse", {31'h0, flush_done}, 32'd0);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
- Sits between GPU_top pixel output and axi_master_burst_axi3.
- Merges accepted 8-bit pixels that fall in the same 4-byte framebuffer word into one 32-bit word with byte strobes, cutting AXI write beats.
- Accumulates one word at a time. Emits it on word completion, group change, idle timeout or frame end.

Parameters:
IDLE_FLUSH, 16, cycles without an accepted draw pixel before a partial word is forced out; 0 disables the timeout.
XY_W, 11, width of pixel_x, pixel_y and the framebuffer width input.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
framebuffer_baseaddr  in  32  byte base address of framebuffer
width  in  XY_W  framebuffer width in pixels; stable during a frame
pixel_x  in  XY_W  pixel column
pixel_y  in  XY_W  pixel row
pixel_data  in  8  pixel colour
pixel_valid  in  1  pixel present
draw  in  1  1 = write pixel, 0 = discard
pixel_ready  out  1  pixel accepted when pixel_valid & pixel_ready
frame_end  in  1  single-cycle pulse: last pixel of frame has been presented
word_addr  out  32  4-byte-aligned byte address
word_data  out  32  packed pixels; byte lane n = bits 8n+7:8n
word_strb  out  4  byte enables
word_valid  out  1  output word valid
word_ready  in  1  downstream accepts word
flush_done  out  1  one-cycle pulse: frame fully drained

Behaviour:
- Addressing: byte_addr = framebuffer_baseaddr + pixel_y*width + pixel_x (index unsigned, 22 bits, zero-extended); group address = byte_addr & ~3; lane = byte_addr[1:0].
- State: accumulator (acc_valid, acc_addr, acc_data, acc_strb); output register (word_*); flush_pending flag; idle counter.
- pixel_ready = !reset & !flush_pending & (!word_valid | word_ready). Combinational.
- Accept with draw=0: pixel dropped; no state change except the idle counter keeps counting.
- Accept with draw=1, acc empty: load acc with lane byte and one-hot strobe.
- Accept with draw=1, same group: write the lane byte; a repeated lane overwrites (last wins); OR the strobe in.
- If the merged strobe == 4'hF, the merged word moves to the output register at the same edge and acc empties.
- Accept with draw=1, different group: acc moves to the output register, the new pixel loads acc, same edge.
- Output register load only occurs when the register is empty or handshaking; this is guaranteed by the pixel_ready rule.
- Output: word_valid held with addr/data/strb stable until word_ready; word_valid clears on handshake unless reloaded the same edge.
- Idle flush (IDLE_FLUSH>0): counter resets on every draw=1 accept and increments while acc_valid.
- On reaching IDLE_FLUSH with the output slot free, acc moves to the output and the counter clears.
- frame_end: sets flush_pending.
- If frame_end coincides with an accept, the pixel is processed first, then flushed.
- While flush_pending: acc moves to the output when the slot is free.
- When acc is empty, word_valid=0 and flush_pending=1: flush_done=1 for one cycle and flush_pending clears.
- Empty frame: frame_end with nothing held gives flush_done the next cycle.
- Latency: a full word is valid the cycle after its 4th pixel is accepted. A partial word is valid the cycle after the triggering event.
- Reset (any time, including mid-word or while flush_pending): word_valid=0, word_addr=0, word_data=0, word_strb=0, flush_done=0, acc discarded, counter=0, flush_pending=0, pixel_ready=0 while reset high.
- No strobe-less word is ever emitted.

Test Plan:
- Base=0, width=800; pixels (0,0)..(3,0) colours 11,22,33,44 back-to-back, word_ready=1 -> one word, addr 0x0, data 0x44332211, strb 4'hF, valid the cycle after the 4th accept.
- (5,0)=AA then (100,0)=BB -> on the 2nd accept, word addr 0x4, data 0x0000AA00, strb 4'b0010; BB held at addr 0x64, lane 0.
- draw=0 pixel (1,0) between (0,0)=01 and (2,0)=03 -> single word addr 0x0, strb 4'b0101, data 0x00030001; pixel_ready stays 1.
- word_ready=0 for 10 cycles with a word pending and a new-group pixel arriving -> pixel_ready=0; word_addr/data/strb stable; no loss; word released on the first word_ready=1.
- (2,1)=5C then frame_end -> word addr 0x320, strb 4'b0100, data 0x005C0000; flush_done pulses the cycle after the handshake.
- Idle flush: IDLE_FLUSH=16, single pixel (7,0)=EE, then idle -> word addr 0x4, strb 4'b1000 appears on IDLE_FLUSH expiry.
- Reset asserted mid-word holding (1,0) -> no word emitted; all outputs 0 next cycle.
